// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding, master IDs and
// default bus widths.
package sdram_port_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W = 25;
   localparam int unsigned DEF_DATA_W = 16;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      CMD  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter_tag_fifo.sv
// Small synchronous FIFO with same-cycle push+pop; holds master IDs of
// outstanding reads so returning data can be routed in issue order.
module tag_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller Avalon-MM port between two
// masters; read data is steered back through an in-order tag queue.
module sdram_port_arbiter
   import sdram_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned MAX_PEND = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic                s_read,
   output logic                s_write,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid,
   output logic                err_orphan
);

   arb_state_t state, state_nxt;
   logic       owner, owner_nxt;
   logic       last, last_nxt;
   logic       elig0, elig1;
   logic       sel_read, sel_write;
   logic       in_cmd, accept;
   logic       tagq_full, tagq_empty, tag_head;

   assign elig0 = m0_write | (m0_read & ~tagq_full);
   assign elig1 = m1_write | (m1_read & ~tagq_full);

   // Owner mux; strobes are additionally qualified by the CMD state.
   assign sel_read     = (owner == M1) ? m1_read : m0_read;
   assign sel_write    = (owner == M1) ? m1_write : m0_write;
   assign s_address    = (owner == M1) ? m1_address : m0_address;
   assign s_writedata  = (owner == M1) ? m1_writedata : m0_writedata;
   assign s_byteenable = (owner == M1) ? m1_byteenable : m0_byteenable;

   assign in_cmd  = (state == CMD) & ~reset;
   assign s_read  = in_cmd & sel_read;
   assign s_write = in_cmd & sel_write;
   assign accept  = in_cmd & ~s_waitrequest & (sel_read | sel_write);

   assign m0_waitrequest = ~(in_cmd & (owner == M0) & ~s_waitrequest);
   assign m1_waitrequest = ~(in_cmd & (owner == M1) & ~s_waitrequest);

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = s_readdatavalid & ~reset & ~tagq_empty & (tag_head == M0);
   assign m1_readdatavalid = s_readdatavalid & ~reset & ~tagq_empty & (tag_head == M1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         owner <= M0;
         last  <= M1;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (elig0 | elig1) begin
               state_nxt = CMD;
               if (elig0 & elig1)
                  owner_nxt = ~last;
               else
                  owner_nxt = elig1 ? M1 : M0;
            end
         end
         CMD: begin
            if (accept) begin
               state_nxt = IDLE;
               last_nxt  = owner;
            end else if (~(sel_read | sel_write)) begin
               // Owner withdrew its request; abandon without a push.
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   tag_fifo #(
      .DEPTH (MAX_PEND),
      .WIDTH (1)
   ) u_tagq (
      .clock (clock),
      .reset (reset),
      .push  (accept & sel_read),
      .din   (owner),
      .pop   (s_readdatavalid),
      .dout  (tag_head),
      .full  (tagq_full),
      .empty (tagq_empty)
   );

   always_ff @(posedge clock) begin
      if (reset)
         err_orphan <= 1'b0;
      else if (s_readdatavalid & tagq_empty)
         err_orphan <= 1'b1;
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scenario tests plus a randomized run checked against a transaction-level
// model of the two-master SDRAM port arbiter.
module tb_sdram_port_arbiter;

   localparam int unsigned AW = 25;
   localparam int unsigned DW = 16;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned MP = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] m0_address, m1_address, s_address;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
   logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic          s_read, s_write, s_waitrequest, s_readdatavalid;
   logic          err_orphan;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
      .clock(clock), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
      .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
      .err_orphan(err_orphan)
   );

   task automatic idle_inputs();
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '1;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '1;
      s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clock);
      #1 reset = 0;
   endtask

   // Holds one command on master m until it is accepted (bounded), then drops it.
   task automatic issue(input bit m, input bit wr);
      int n;
      if (m) begin m1_read = !wr; m1_write = wr; m1_address = AW'($urandom); end
      else   begin m0_read = !wr; m0_write = wr; m0_address = AW'($urandom); end
      s_waitrequest = 0;
      for (n = 0; n < 8; n++) begin
         @(negedge clock);
         if ((m ? m1_waitrequest : m0_waitrequest) === 1'b0) break;
         @(posedge clock); #1;
      end
      checks++;
      if (n == 8) begin errors++; $display("FAIL issue_timeout: master %0d not accepted in 8 cycles", m); end
      @(posedge clock); #1;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; m0_read = 1; m1_write = 1; s_readdatavalid = 1;
      repeat (2) begin @(posedge clock); #1; end
      @(negedge clock);
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_read, s_write, m0_readdatavalid, m1_readdatavalid} !== 6'b110000) begin
         errors++;
         $display("FAIL rst_outputs: got %b exp 110000", {m0_waitrequest, m1_waitrequest, s_read, s_write, m0_readdatavalid, m1_readdatavalid});
      end
      @(posedge clock); #1;
      reset = 0; idle_inputs();
      @(negedge clock);
      checks++;
      if (err_orphan !== 1'b0 || dut.u_tagq.count !== 3'd0) begin
         errors++; $display("FAIL rst_state: err_orphan %b count %0d exp 0 0", err_orphan, dut.u_tagq.count);
      end
      checks++;
      if (s_read !== 1'b0 || s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin
         errors++; $display("FAIL rst_idle: s_read %b s_write %b m0_wait %b", s_read, s_write, m0_waitrequest);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_single_write();
      do_reset();
      m0_address = 25'h0000123; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
      m0_write = 1; s_waitrequest = 1;
      @(negedge clock);
      checks++;
      if (s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin
         errors++; $display("FAIL wr_idle: s_write %b m0_wait %b exp 0 1", s_write, m0_waitrequest);
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clock); #1 s_waitrequest = (c < 3);
         @(negedge clock);
         checks++;
         if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 25'h0000123 || s_writedata !== 16'hBEEF || s_byteenable !== 2'b11) begin
            errors++; $display("FAIL wr_cmd: cyc %0d s_write %b addr %h data %h", c, s_write, s_address, s_writedata);
         end
         checks++;
         if (m0_waitrequest !== (c < 3)) begin
            errors++; $display("FAIL wr_m0_wait: cyc %0d got %b exp %b", c, m0_waitrequest, (c < 3));
         end
         checks++;
         if (m1_waitrequest !== 1'b1 || m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL wr_m1: wait %b rdv %b exp 1 0", m1_waitrequest, m1_readdatavalid);
         end
      end
      @(posedge clock); #1 m0_write = 0; s_waitrequest = 0;
      @(negedge clock);
      checks++;
      if (s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin
         errors++; $display("FAIL wr_done: s_write %b m0_wait %b exp 0 1", s_write, m0_waitrequest);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_contention();
      int due[$];
      int grants = 0, rets = 0, got0 = 0, got1 = 0;
      bit exp_m;
      logic [DW-1:0] exp_d;
      do_reset();
      m0_address = AW'($urandom); m1_address = AW'($urandom);
      m0_read = 1; m1_read = 1;
      for (int t = 0; t < 80 && rets < 8; t++) begin
         s_readdatavalid = 0;
         if (due.size() > 0 && due[0] == t) begin
            void'(due.pop_front());
            s_readdatavalid = 1; s_readdata = 16'hA000 + 16'(rets);
         end
         @(negedge clock);
         if (s_readdatavalid) begin
            exp_m = rets[0]; exp_d = 16'hA000 + 16'(rets);
            checks++;
            if ({m1_readdatavalid, m0_readdatavalid} !== (exp_m ? 2'b10 : 2'b01) || (exp_m ? m1_readdata : m0_readdata) !== exp_d) begin
               errors++; $display("FAIL ct_route: ret %0d rdv1/0 %b%b data %h exp master %0d data %h", rets, m1_readdatavalid, m0_readdatavalid, s_readdata, exp_m, exp_d);
            end
            if (m0_readdatavalid) got0++;
            if (m1_readdatavalid) got1++;
            rets++;
         end
         if ((s_read & ~s_waitrequest) === 1'b1) begin
            exp_m = grants[0];
            checks++;
            if ({m1_waitrequest, m0_waitrequest} !== (exp_m ? 2'b01 : 2'b10)) begin
               errors++; $display("FAIL ct_order: grant %0d wait1/0 %b%b exp master %0d", grants, m1_waitrequest, m0_waitrequest, exp_m);
            end
            due.push_back(t + 2);
            grants++;
         end
         @(posedge clock); #1;
         if (grants >= 7) m0_read = 0;
         if (grants >= 8) m1_read = 0;
      end
      checks++;
      if (grants != 8 || got0 != 4 || got1 != 4) begin
         errors++; $display("FAIL ct_counts: grants %0d m0 rdv %0d m1 rdv %0d exp 8 4 4", grants, got0, got1);
      end
      idle_inputs();
   endtask

   task automatic test_queue_full();
      bit w_acc = 0, granted = 0;
      do_reset();
      repeat (4) issue(1'b1, 1'b0);
      checks++;
      if (dut.u_tagq.count !== 3'd4) begin errors++; $display("FAIL qf_count: got %0d exp 4", dut.u_tagq.count); end
      m0_read = 1; m0_address = 25'h1AAAAAA;
      m1_write = 1; m1_writedata = 16'h5A5A; m1_address = 25'h0055555;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         checks++;
         if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL qf_m0_stall: cyc %0d m0_wait %b exp 1", c, m0_waitrequest); end
         if (m1_waitrequest === 1'b0 && s_write === 1'b1 && s_writedata === 16'h5A5A) w_acc = 1;
         @(posedge clock); #1;
         if (w_acc) m1_write = 0;
      end
      checks++;
      if (!w_acc) begin errors++; $display("FAIL qf_write: m1 write accepted %b exp 1", w_acc); end
      s_readdatavalid = 1; s_readdata = 16'h1111;
      @(negedge clock);
      checks++;
      if ({m1_readdatavalid, m0_readdatavalid} !== 2'b10) begin
         errors++; $display("FAIL qf_ret: rdv1/0 %b%b exp 10", m1_readdatavalid, m0_readdatavalid);
      end
      @(posedge clock); #1 s_readdatavalid = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (m0_waitrequest === 1'b0) begin
            granted = 1;
            checks++;
            if (s_read !== 1'b1 || s_address !== 25'h1AAAAAA) begin
               errors++; $display("FAIL qf_m0_cmd: s_read %b addr %h exp 1 1aaaaaa", s_read, s_address);
            end
            break;
         end
         @(posedge clock); #1;
      end
      checks++;
      if (!granted) begin errors++; $display("FAIL qf_m0_grant: m0 read not granted after pop"); end
      @(posedge clock); #1 m0_read = 0;
      for (int k = 0; k < 4; k++) begin
         s_readdatavalid = 1; s_readdata = 16'(k);
         @(negedge clock);
         checks++;
         if (m0_readdatavalid !== (k == 3) || m1_readdatavalid !== (k != 3)) begin
            errors++; $display("FAIL qf_drain: ret %0d rdv1/0 %b%b", k, m1_readdatavalid, m0_readdatavalid);
         end
         @(posedge clock); #1;
      end
      s_readdatavalid = 0;
   endtask

   task automatic test_push_pop();
      bit ids[$];
      bit b;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         b = 1'($urandom);
         issue(b, 1'b0);
         ids.push_back(b);
      end
      checks++;
      if (dut.u_tagq.count !== 3'd3) begin errors++; $display("FAIL pp_count_pre: got %0d exp 3", dut.u_tagq.count); end
      m1_read = 1; m1_address = 25'h0ABCDEF;
      @(posedge clock); #1 s_readdatavalid = 1; s_readdata = 16'hC0DE;
      @(negedge clock);
      checks++;
      if (s_read !== 1'b1 || m1_waitrequest !== 1'b0) begin
         errors++; $display("FAIL pp_accept: s_read %b m1_wait %b exp 1 0", s_read, m1_waitrequest);
      end
      checks++;
      if (m0_readdatavalid !== !ids[0] || m1_readdatavalid !== ids[0]) begin
         errors++; $display("FAIL pp_route: rdv1/0 %b%b exp head %0d", m1_readdatavalid, m0_readdatavalid, ids[0]);
      end
      @(posedge clock); #1 m1_read = 0; s_readdatavalid = 0;
      @(negedge clock);
      checks++;
      if (dut.u_tagq.count !== 3'd3) begin errors++; $display("FAIL pp_count_post: got %0d exp 3", dut.u_tagq.count); end
      void'(ids.pop_front());
      ids.push_back(1'b1);
      @(posedge clock); #1;
      for (int k = 0; k < 3; k++) begin
         s_readdatavalid = 1;
         @(negedge clock);
         checks++;
         if (m0_readdatavalid !== !ids[k] || m1_readdatavalid !== ids[k]) begin
            errors++; $display("FAIL pp_drain: ret %0d rdv1/0 %b%b exp master %0d", k, m1_readdatavalid, m0_readdatavalid, ids[k]);
         end
         @(posedge clock); #1;
      end
      s_readdatavalid = 0;
   endtask

   task automatic test_orphan();
      s_readdatavalid = 1; s_readdata = 16'hDEAD;
      @(negedge clock);
      checks++;
      if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         errors++; $display("FAIL orph_rdv: rdv1/0 %b%b exp 00", m1_readdatavalid, m0_readdatavalid);
      end
      @(posedge clock); #1 s_readdatavalid = 0;
      @(negedge clock);
      checks++;
      if (err_orphan !== 1'b1) begin errors++; $display("FAIL orph_set: err_orphan %b exp 1", err_orphan); end
      @(posedge clock); #1;
      issue(1'b0, 1'b1);
      repeat (4) @(posedge clock);
      #1;
      checks++;
      if (err_orphan !== 1'b1 || dut.u_tagq.count !== 3'd0) begin
         errors++; $display("FAIL orph_sticky: err_orphan %b count %0d exp 1 0", err_orphan, dut.u_tagq.count);
      end
   endtask

   task automatic test_mid_reset();
      issue(1'b0, 1'b0);
      issue(1'b1, 1'b0);
      checks++;
      if (dut.u_tagq.count !== 3'd2) begin errors++; $display("FAIL mr_pending: got %0d exp 2", dut.u_tagq.count); end
      m0_read = 1; s_waitrequest = 1;
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (s_read !== 1'b1) begin errors++; $display("FAIL mr_cmd: s_read %b exp 1", s_read); end
      @(posedge clock); #1 reset = 1;
      @(negedge clock);
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_read} !== 3'b110) begin
         errors++; $display("FAIL mr_during: wait0/1 s_read %b exp 110", {m0_waitrequest, m1_waitrequest, s_read});
      end
      @(posedge clock); #1 reset = 0; m1_read = 1; s_waitrequest = 0; s_readdatavalid = 1;
      @(negedge clock);
      checks++;
      if ({m0_waitrequest, m1_waitrequest, s_read, err_orphan} !== 4'b1100 || dut.u_tagq.count !== 3'd0) begin
         errors++; $display("FAIL mr_after: wait0/1 s_read orphan %b count %0d exp 1100 0", {m0_waitrequest, m1_waitrequest, s_read, err_orphan}, dut.u_tagq.count);
      end
      checks++;
      if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         errors++; $display("FAIL mr_stale_rdv: rdv1/0 %b%b exp 00", m1_readdatavalid, m0_readdatavalid);
      end
      @(posedge clock); #1 s_readdatavalid = 0;
      @(negedge clock);
      checks++;
      if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
         errors++; $display("FAIL mr_tie: wait0/1 %b%b exp 01", m0_waitrequest, m1_waitrequest);
      end
      checks++;
      if (err_orphan !== 1'b1) begin errors++; $display("FAIL mr_orphan: err_orphan %b exp 1", err_orphan); end
      @(posedge clock); #1 m0_read = 0; m1_read = 0;
      s_readdatavalid = 1;
      @(negedge clock);
      checks++;
      if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL mr_ret: m0 rdv %b exp 1", m0_readdatavalid); end
      @(posedge clock); #1 s_readdatavalid = 0;
   endtask

   // Transaction-level model: pending requests per master, expected grant from the
   // round-robin rule, and a queue of issuing masters for returned data.
   task automatic test_random();
      bit act [2]; bit wr [2];
      logic [AW-1:0] ad [2]; logic [DW-1:0] wd [2]; logic [BW-1:0] be [2];
      bit phase = 0, own = 0, lastm = 1, e0, e1, h, new_rd;
      bit expq[$];
      logic [DW-1:0] rv;
      do_reset();
      act[0] = 0; act[1] = 0; wr[0] = 0; wr[1] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int m = 0; m < 2; m++) begin
            if (!act[m] && cyc < 2800 && $urandom_range(0, 2) != 0) begin
               act[m] = 1; wr[m] = 1'($urandom); ad[m] = AW'($urandom);
               wd[m] = DW'($urandom); be[m] = BW'($urandom);
            end
         end
         m0_read = act[0] & !wr[0]; m0_write = act[0] & wr[0];
         m0_address = ad[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
         m1_read = act[1] & !wr[1]; m1_write = act[1] & wr[1];
         m1_address = ad[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
         s_waitrequest = ($urandom_range(0, 2) == 0);
         s_readdatavalid = 0;
         if (expq.size() > 0 && $urandom_range(0, 2) == 0) begin
            rv = DW'($urandom); s_readdatavalid = 1; s_readdata = rv;
         end
         @(negedge clock);
         new_rd = 0;
         if (!phase) begin
            checks++;
            if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin
               errors++; $display("FAIL rnd_idle: cyc %0d s_read s_write wait0 wait1 %b exp 0011", cyc, {s_read, s_write, m0_waitrequest, m1_waitrequest});
            end
            e0 = act[0] && (wr[0] || expq.size() < MP);
            e1 = act[1] && (wr[1] || expq.size() < MP);
            if (e0 || e1) begin
               phase = 1;
               own = (e0 && e1) ? !lastm : e1;
            end
         end else begin
            checks++;
            if (s_read !== !wr[own] || s_write !== wr[own] || s_address !== ad[own]) begin
               errors++; $display("FAIL rnd_cmd: cyc %0d owner %0d rd %b wr %b addr %h exp addr %h", cyc, own, s_read, s_write, s_address, ad[own]);
            end
            if (wr[own]) begin
               checks++;
               if (s_writedata !== wd[own] || s_byteenable !== be[own]) begin
                  errors++; $display("FAIL rnd_wdata: cyc %0d got %h/%b exp %h/%b", cyc, s_writedata, s_byteenable, wd[own], be[own]);
               end
            end
            checks++;
            if (m0_waitrequest !== !(own == 0 && !s_waitrequest) || m1_waitrequest !== !(own == 1 && !s_waitrequest)) begin
               errors++; $display("FAIL rnd_wait: cyc %0d owner %0d wait0/1 %b%b", cyc, own, m0_waitrequest, m1_waitrequest);
            end
            if (!s_waitrequest) begin
               lastm = own; phase = 0; act[own] = 0;
               new_rd = !wr[own];
            end
         end
         checks++;
         if (s_readdatavalid) begin
            h = expq.pop_front();
            if (m0_readdatavalid !== !h || m1_readdatavalid !== h || (h ? m1_readdata : m0_readdata) !== rv) begin
               errors++; $display("FAIL rnd_ret: cyc %0d rdv1/0 %b%b exp master %0d data %h", cyc, m1_readdatavalid, m0_readdatavalid, h, rv);
            end
         end else if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rnd_spurious: cyc %0d rdv1/0 %b%b exp 00", cyc, m1_readdatavalid, m0_readdatavalid);
         end
         if (new_rd) expq.push_back(own);
         @(posedge clock); #1;
      end
      checks++;
      if (expq.size() != 0 || act[0] || act[1] || err_orphan !== 1'b0) begin
         errors++; $display("FAIL rnd_end: pending %0d act %b%b orphan %b exp 0 00 0", expq.size(), act[0], act[1], err_orphan);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      test_reset();
      test_single_write();
      test_contention();
      test_queue_full();
      test_push_pop();
      test_orphan();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
